// File: rtl/maxpool_stream_ctrl_if.sv
// Pixel-in / pooled-result-out stream bundle for maxpool_stream_ctrl.
// The controller takes the slave view; the producer/consumer side takes master.
interface maxpool_stream_ctrl_if #(
   parameter int BITWIDTH = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [BITWIDTH-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [BITWIDTH-1:0] out_data;
   logic                out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/maxpool_stream_ctrl.sv
// Streaming 2-D max-pooling controller: one pixel per beat in, one pooled
// maximum per completed KHEIGHT x KWIDTH window out, via a line of partial maxima.
module maxpool_stream_ctrl #(
   parameter int BITWIDTH    = 8,
   parameter int DATAWIDTH   = 28,
   parameter int DATAHEIGHT  = 28,
   parameter int DATACHANNEL = 3,
   parameter int KWIDTH      = 2,
   parameter int KHEIGHT     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   maxpool_stream_ctrl_if.slave stream,
   output logic                 busy,
   output logic                 done
);
   localparam int OW  = DATAWIDTH / KWIDTH;
   localparam int OH  = DATAHEIGHT / KHEIGHT;
   localparam int CW  = (DATAWIDTH   > 1) ? $clog2(DATAWIDTH)   : 1;
   localparam int RW  = (DATAHEIGHT  > 1) ? $clog2(DATAHEIGHT)  : 1;
   localparam int CHW = (DATACHANNEL > 1) ? $clog2(DATACHANNEL) : 1;
   localparam int KXW = (KWIDTH      > 1) ? $clog2(KWIDTH)      : 1;
   localparam int KYW = (KHEIGHT     > 1) ? $clog2(KHEIGHT)     : 1;
   localparam int OXW = (OW          > 1) ? $clog2(OW)          : 1;
   localparam int OYW = (OH          > 1) ? $clog2(OH)          : 1;

   localparam logic [CW-1:0]  COL_LAST = CW'(DATAWIDTH - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(DATAHEIGHT - 1);
   localparam logic [CHW-1:0] CH_LAST  = CHW'(DATACHANNEL - 1);
   localparam logic [KXW-1:0] KX_LAST  = KXW'(KWIDTH - 1);
   localparam logic [KYW-1:0] KY_LAST  = KYW'(KHEIGHT - 1);
   localparam logic [OXW-1:0] OX_LAST  = OXW'(OW - 1);
   localparam logic [OYW-1:0] OY_LAST  = OYW'(OH - 1);
   localparam logic [CW:0]    COL_LIM  = (CW+1)'(OW * KWIDTH);
   localparam logic [RW:0]    ROW_LIM  = (RW+1)'(OH * KHEIGHT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]          state;
   logic [CW-1:0]       col;
   logic [RW-1:0]       row;
   logic [CHW-1:0]      ch;
   logic [KXW-1:0]      kx;
   logic [KYW-1:0]      ky;
   logic [OXW-1:0]      ox;
   logic [OYW-1:0]      oy;
   logic [BITWIDTH-1:0] hmax;
   logic [BITWIDTH-1:0] linebuf [OW];
   logic                ov_q;
   logic                ol_q;
   logic [BITWIDTH-1:0] od_q;

   logic                accept;
   logic                col_in;
   logic                row_in;
   logic                col_last;
   logic                row_last;
   logic                ch_last;
   logic                kx_last;
   logic                ky_last;
   logic                emit;
   logic [BITWIDTH-1:0] hcur;
   logic [BITWIDTH-1:0] vmax;

   function automatic logic [BITWIDTH-1:0] umax(input logic [BITWIDTH-1:0] a,
                                                input logic [BITWIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // rst gates in_ready combinationally so no beat is taken in a reset cycle
   assign stream.in_ready  = (state == ST_RUN) && !rst && (!ov_q || stream.out_ready);
   assign stream.out_valid = ov_q;
   assign stream.out_data  = od_q;
   assign stream.out_last  = ol_q;
   assign busy             = (state != ST_IDLE);

   assign accept   = stream.in_valid && stream.in_ready;
   assign col_in   = {1'b0, col} < COL_LIM;
   assign row_in   = {1'b0, row} < ROW_LIM;
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);
   assign ch_last  = (ch == CH_LAST);
   assign kx_last  = (kx == KX_LAST);
   assign ky_last  = (ky == KY_LAST);
   assign emit     = accept && col_in && row_in && kx_last && ky_last;

   always_comb begin
      hcur = stream.in_data;
      if (kx != '0) hcur = umax(hmax, stream.in_data);
      vmax = hcur;
      if (KHEIGHT > 1) vmax = umax(linebuf[ox], hcur);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         col   <= '0;
         row   <= '0;
         ch    <= '0;
         kx    <= '0;
         ky    <= '0;
         ox    <= '0;
         oy    <= '0;
         ov_q  <= 1'b0;
         ol_q  <= 1'b0;
         od_q  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE:  if (start) state <= ST_RUN;
            ST_RUN:   if (accept && col_last && row_last && ch_last) state <= ST_FLUSH;
            ST_FLUSH: if (!ov_q || stream.out_ready) begin
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default:  state <= ST_IDLE;
         endcase

         // window counters wrap early on trailing columns/rows; ox/oy hold 0 there
         if (accept) begin
            kx <= (kx_last || col_last) ? '0 : kx + 1'b1;
            if (col_in && kx_last) ox <= (ox == OX_LAST) ? '0 : ox + 1'b1;
            if (col_last) begin
               col <= '0;
               ox  <= '0;
               ky  <= (ky_last || row_last) ? '0 : ky + 1'b1;
               if (row_in && ky_last) oy <= (oy == OY_LAST) ? '0 : oy + 1'b1;
               if (row_last) begin
                  row <= '0;
                  oy  <= '0;
                  ch  <= ch_last ? '0 : ch + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end

         if (emit) begin
            ov_q <= 1'b1;
            od_q <= vmax;
            ol_q <= (ox == OX_LAST) && (oy == OY_LAST);
         end else if (ov_q && stream.out_ready) begin
            ov_q <= 1'b0;
            ol_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && col_in) hmax <= hcur;
      if (accept && col_in && row_in && kx_last && !ky_last) begin
         if (ky == '0) linebuf[ox] <= hcur;
         else          linebuf[ox] <= umax(linebuf[ox], hcur);
      end
   end
endmodule

// File: doc/maxpool_stream_ctrl.md
Name: maxpool_stream_ctrl

Overview:
- Streaming controller/scheduler for 2-D max pooling over a feature map delivered one pixel per beat.
- Sequences row/column/channel counters, keeps a line buffer of partial window maxima, and emits one pooled value per completed KHEIGHT x KWIDTH window.
- Sits between the conv/activation output stream and the next layer, replacing the fully parallel pooling array when area matters.

Parameters:
- BITWIDTH, 8, pixel width; unsigned.
- DATAWIDTH, 28, input columns.
- DATAHEIGHT, 28, input rows.
- DATACHANNEL, 3, input channels.
- KWIDTH, 2, window width; horizontal stride = KWIDTH.
- KHEIGHT, 2, window height; vertical stride = KHEIGHT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  controller accepts a pixel this cycle.
- in_data  in  BITWIDTH  input pixel.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  BITWIDTH  pooled maximum.
- out_last  out  1  high with the final result of each channel.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when a frame is fully drained.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - state = IDLE; all counters = 0.
  - in_ready, out_valid, out_data, out_last, busy and done = 0.
  - Line buffer contents are don't-care.
- Input order: channel-major, then row, then column.
  - Pixel index = ch*DATAHEIGHT*DATAWIDTH + row*DATAWIDTH + col.
- Derived sizes: OW = DATAWIDTH/KWIDTH and OH = DATAHEIGHT/KHEIGHT, both floor.
  - Trailing columns with col >= OW*KWIDTH are accepted and discarded.
  - Trailing rows with row >= OH*KHEIGHT are accepted and discarded.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: in_ready = 0. start -> RUN. start in any other state is ignored.
  - RUN: in_ready = !out_valid || out_ready. A beat transfers on in_valid && in_ready.
    - After the transfer of the last pixel (ch = DATACHANNEL-1, row = DATAHEIGHT-1, col = DATAWIDTH-1) -> FLUSH.
  - FLUSH: in_ready = 0. Once out_valid = 0, or on the same cycle it is consumed: pulse done for 1 cycle -> IDLE.
- Counters advance only on accepted beats.
  - col wraps DATAWIDTH-1 -> 0 and increments row.
  - row wraps DATAHEIGHT-1 -> 0 and increments ch.
  - ch wraps to 0 at frame end.
- Datapath per accepted in-window pixel:
  - hmax = in_data at kx = 0; otherwise hmax = max(hmax, in_data), where kx = col mod KWIDTH.
  - At kx = KWIDTH-1, the window column is complete. Let h = that cycle's max, ox = col/KWIDTH, ky = row mod KHEIGHT:
    - ky = 0: linebuf[ox] = h.
    - 0 < ky < KHEIGHT-1: linebuf[ox] = max(linebuf[ox], h).
    - ky = KHEIGHT-1: emit max(linebuf[ox], h). Set out_data to it and out_valid = 1 on the next edge (latency 1 cycle from the completing beat).
  - Comparisons are unsigned, full BITWIDTH; no width growth.
  - Special cases: KHEIGHT = 1 emits directly from h; KWIDTH = 1 makes h = in_data.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new result loads the same cycle.
  - Holding out_valid with out_ready = 0 deasserts in_ready, so no result is ever dropped or overwritten.
- out_last = 1 with the result at ox = OW-1, oy = OH-1 of each channel.
- busy = (state != IDLE).
- in_valid with in_ready = 0 has no effect.
- rst mid-frame aborts the frame: no done pulse, pending output discarded.

Test Plan:
- Reset hold:
  - Assert rst 3 cycles with in_valid = 1 and start = 1 -> all outputs 0 and state IDLE throughout.
  - After release with no start, in_ready stays 0.
- Basic 4x4, 1 channel, K = 2x2, in_data = index 0..15, out_ready = 1:
  - outputs 5, 7, 13, 15, one cycle after beats 5, 7, 13, 15.
  - out_last only with 15; done one cycle after last output, then busy = 0.
- Unsigned compare, 2x2, 1 channel, pixels {0xFF, 0x01, 0x80, 0x7F} -> single output 0xFF.
- Odd size, 5x5, 2 channels, K = 2x2, constant pixel = channel+1:
  - 4 outputs per channel (1,1,1,1 then 2,2,2,2).
  - All 50 beats accepted; col 4 and row 4 discarded; out_last on results 4 and 8.
- Backpressure, default 28x28x3:
  - Random in_valid and out_ready at 50% each.
  - 588 outputs match a software model in order.
  - in_ready = 0 whenever out_valid && !out_ready; no duplicated results.
- Abort: assert rst after 10 accepted beats -> out_valid 0 next cycle, no done.
  - A new start then processes a clean frame with correct results.
